issue_queue: RTL and testbench
==============================

# issue_queue

Reservation-station issue queue sitting directly upstream of the execute stage. It buffers up to DEPTH decoded ALU operations from dispatch, waits for unresolved source operands via common-data-bus (CDB) tag broadcasts, then issues one fully-ready operation per cycle. Its registered outputs drive execute's operand-select, function and operand inputs.

## Interface
- WORD, 32, operand/immediate width
- ADDR_LEN, 32, PC width
- DEPTH, 4, entries (power of two, ≥2)
- TAG_W, 4, physical/ROB tag width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all entries and the issue register
- disp_valid  in  1  dispatch op present
- disp_ready  out  1  at least one free entry
- disp_opsel1, disp_opsel2  in  2  operand-select codes, passed through
- disp_alu_func  in  4  ALU function, passed through
- disp_rs1_rdy, disp_rs2_rdy  in  1  source value already valid
- disp_rs1_value, disp_rs2_value  in  WORD  source values (meaningful when rdy)
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  producer tags (meaningful when !rdy)
- disp_imm  in  WORD  immediate
- disp_pc  in  ADDR_LEN  instruction PC
- disp_dest_tag  in  TAG_W  destination tag
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  WORD  broadcast value
- iss_ready  in  1  downstream accepts (execute ties high)
- iss_valid  out  1  issue register holds an op
- iss_opsel1, iss_opsel2  out  2
- iss_alu_func  out  4
- iss_rs1_value, iss_rs2_value  out  WORD
- iss_imm  out  WORD
- iss_pc  out  ADDR_LEN
- iss_dest_tag  out  TAG_W

## Operation
- Entry fields: valid, opsel1/2, alu_func, rdy1/val1/tag1, rdy2/val2/tag2, imm, pc, dest_tag.
- Dispatch: accepted when disp_valid && disp_ready; written into the lowest-index free entry. disp_ready = any entry invalid, computed from registered state only (an entry freed by issue this cycle does not raise disp_ready until next cycle).
- Wakeup: every valid entry whose operand is not ready and tag == cdb_tag while cdb_valid captures cdb_value and sets rdy at the edge.
- Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a same-cycle CDB broadcast is stored rdy=1 with cdb_value.
- Select: candidates are valid entries with rdy1 && rdy2. Selection occurs only when !iss_valid || iss_ready; the chosen entry is copied into the issue register and invalidated at the same edge. If no candidate, iss_valid clears (when iss_ready).
- Stall: iss_valid && !iss_ready holds all iss_* outputs stable; no entry is freed.
- Flush: all entry valid bits and iss_valid clear; dispatch and CDB updates in that cycle are discarded. Flush takes precedence over everything except reset.

## Timing
- Reset: all entry valid bits 0, iss_valid 0, all iss_* data outputs 0, disp_ready 1 the cycle after reset deasserts.
- Minimum latency: op dispatched ready in cycle N is written at edge N, selected in N+1, visible on iss_* in N+2.
- Wakeup-to-issue: CDB in cycle N sets rdy at edge N, issue visible in N+2.
- Full: DEPTH valid entries → disp_ready 0; a dispatch with disp_valid high is held by the producer.
- Simultaneous dispatch + issue into/out of the same index is impossible (new op takes a currently-free index).
- Reset mid-operation discards all contents identically to flush.

## Configuration
- ISSUE_AGE_SELECT_EN defined: oldest-ready select via a DEPTH×DEPTH age matrix updated on dispatch (new entry younger than all valid entries) and cleared on issue/flush.
- Not defined: lowest-index ready entry wins; no age state instantiated.

## Structure
- Shared package: entry struct typedef, opsel/alu_func widths, default WORD/ADDR_LEN/TAG_W constants shared with execute.
- One sub-module: issue_select (priority/age-based one-hot picker over the ready vector).

## Test plan
- Dispatch ready op (rs1=5, rs2=7, func ADD, dest 3) in cycle 0 → iss_valid=1 with values 5/7, dest 3, in cycle 2.
- Dispatch op with rs1 tag 9 not ready; cdb_valid tag 9 value 0x100 in cycle 3 → issue in cycle 5 with iss_rs1_value=0x100.
- CDB tag 2 value 0x55 in the same cycle as dispatch of op waiting on tag 2 → entry stored ready, issues 2 cycles later with 0x55.
- Fill 4 entries all waiting on tag 1 → disp_ready=0; broadcast tag 1 → four consecutive issues, disp_ready=1 the cycle after the first issue.
- iss_ready held low 3 cycles with iss_valid=1 → iss_* stable, queue contents unchanged; release → next op issues following cycle.
- With ISSUE_AGE_SELECT_EN: dispatch A into entry 2, then B into entry 0, wake both together → A issues first; without macro → B issues first. Flush with 3 valid entries → iss_valid=0, disp_ready=1 next cycle.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types and default widths for the issue queue and the execute stage.
// ISSUE_AGE_SELECT_EN (optional define) switches issue selection to oldest-ready.
package issue_queue_pkg;

  localparam int unsigned IQ_WORD     = 32;
  localparam int unsigned IQ_ADDR_LEN = 32;
  localparam int unsigned IQ_TAG_W    = 4;
  localparam int unsigned OPSEL_W     = 2;
  localparam int unsigned ALU_FUNC_W  = 4;

  typedef logic [OPSEL_W-1:0]    opsel_t;
  typedef logic [ALU_FUNC_W-1:0] alu_func_t;
  typedef logic [IQ_TAG_W-1:0]   tag_t;

  // One reservation-station slot; operand value is meaningful once rdy is set.
  typedef struct packed {
    logic                   valid;
    opsel_t                 opsel1;
    opsel_t                 opsel2;
    alu_func_t              alu_func;
    logic                   rdy1;
    logic [IQ_WORD-1:0]     val1;
    tag_t                   tag1;
    logic                   rdy2;
    logic [IQ_WORD-1:0]     val2;
    tag_t                   tag2;
    logic [IQ_WORD-1:0]     imm;
    logic [IQ_ADDR_LEN-1:0] pc;
    tag_t                   dest_tag;
  } iq_entry_t;

  // An outstanding operand captures a CDB broadcast carrying its producer tag.
  function automatic logic operand_wakes(input logic rdy, input tag_t tag,
                                         input logic cdb_valid, input tag_t cdb_tag);
    return !rdy && cdb_valid && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/issue_select.sv
// One-hot picker over the ready vector of the issue queue.
// ISSUE_AGE_SELECT_EN defined: oldest ready entry wins using the age matrix.
// Otherwise: lowest-index ready entry wins.
module issue_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0] ready_vec,
`ifdef ISSUE_AGE_SELECT_EN
  input  logic [DEPTH-1:0] age [DEPTH],
`endif
  output logic [DEPTH-1:0] grant,
  output logic             any
);

`ifdef ISSUE_AGE_SELECT_EN
  // age[j][i] set means entry j is older than entry i; grant the ready entry
  // that no other ready entry is older than.
  always_comb begin
    logic [DEPTH-1:0] older_col;
    grant     = '0;
    older_col = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        older_col[j] = age[j][i];
      end
      grant[i] = ready_vec[i] && ((ready_vec & older_col) == '0);
    end
    any = |ready_vec;
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |ready_vec;
  end
`endif

endmodule

// File: rtl/issue_queue.sv
// Reservation-station issue queue feeding the execute stage.
// Buffers DEPTH ALU ops, wakes operands from CDB broadcasts, issues one ready op
// per cycle into a registered issue stage. Width parameters must match the
// issue_queue_pkg constants since the entry struct is shared with execute.
// ISSUE_AGE_SELECT_EN defined: oldest-ready selection via an age matrix.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned WORD     = IQ_WORD,
  parameter int unsigned ADDR_LEN = IQ_ADDR_LEN,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = IQ_TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [1:0]          disp_opsel1,
  input  logic [1:0]          disp_opsel2,
  input  logic [3:0]          disp_alu_func,
  input  logic                disp_rs1_rdy,
  input  logic                disp_rs2_rdy,
  input  logic [WORD-1:0]     disp_rs1_value,
  input  logic [WORD-1:0]     disp_rs2_value,
  input  logic [TAG_W-1:0]    disp_rs1_tag,
  input  logic [TAG_W-1:0]    disp_rs2_tag,
  input  logic [WORD-1:0]     disp_imm,
  input  logic [ADDR_LEN-1:0] disp_pc,
  input  logic [TAG_W-1:0]    disp_dest_tag,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [WORD-1:0]     cdb_value,
  input  logic                iss_ready,
  output logic                iss_valid,
  output logic [1:0]          iss_opsel1,
  output logic [1:0]          iss_opsel2,
  output logic [3:0]          iss_alu_func,
  output logic [WORD-1:0]     iss_rs1_value,
  output logic [WORD-1:0]     iss_rs2_value,
  output logic [WORD-1:0]     iss_imm,
  output logic [ADDR_LEN-1:0] iss_pc,
  output logic [TAG_W-1:0]    iss_dest_tag
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        disp_ent;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] sel_onehot;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             can_select;
  logic             issue_fire;
  logic             disp_fire;

  // Occupancy and issue-candidate vectors from registered state.
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
  end

  // Lowest-index free slot for dispatch.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!valid_vec[i-1]) free_idx = IDX_W'(i-1);
    end
  end

  // Encode the one-hot grant into an entry index.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_onehot[i]) sel_idx = IDX_W'(i);
    end
  end

  assign disp_ready = ~&valid_vec;
  assign disp_fire  = disp_valid && disp_ready;
  assign can_select = !iss_valid || iss_ready;
  assign issue_fire = can_select && sel_any;

  // Build the incoming entry, catching a same-cycle CDB broadcast for its operands.
  always_comb begin
    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.opsel1   = disp_opsel1;
    disp_ent.opsel2   = disp_opsel2;
    disp_ent.alu_func = disp_alu_func;
    disp_ent.tag1     = disp_rs1_tag;
    disp_ent.tag2     = disp_rs2_tag;
    disp_ent.imm      = disp_imm;
    disp_ent.pc       = disp_pc;
    disp_ent.dest_tag = disp_dest_tag;
    disp_ent.rdy1     = disp_rs1_rdy || operand_wakes(1'b0, disp_rs1_tag, cdb_valid, cdb_tag);
    disp_ent.val1     = disp_rs1_rdy ? disp_rs1_value : cdb_value;
    disp_ent.rdy2     = disp_rs2_rdy || operand_wakes(1'b0, disp_rs2_tag, cdb_valid, cdb_tag);
    disp_ent.val2     = disp_rs2_rdy ? disp_rs2_value : cdb_value;
  end

`ifdef ISSUE_AGE_SELECT_EN
  logic [DEPTH-1:0] age_q [DEPTH];

  // Age matrix: row i bit j set when entry i is older than entry j.
  // A new entry is younger than every entry that stays valid past this edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      if (issue_fire) begin
        age_q[sel_idx] <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) age_q[j][sel_idx] <= 1'b0;
      end
      if (disp_fire) begin
        age_q[free_idx] <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          age_q[j][free_idx] <= valid_vec[j] && !(issue_fire && sel_onehot[j]);
        end
      end
    end
  end

  issue_select #(.DEPTH(DEPTH)) u_select (
    .ready_vec (ready_vec),
    .age       (age_q),
    .grant     (sel_onehot),
    .any       (sel_any)
  );
`else
  issue_select #(.DEPTH(DEPTH)) u_select (
    .ready_vec (ready_vec),
    .grant     (sel_onehot),
    .any       (sel_any)
  );
`endif

  // Entry storage: wakeup, free on issue, write on dispatch (free slot never the issued one).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && operand_wakes(ent_q[i].rdy1, ent_q[i].tag1, cdb_valid, cdb_tag)) begin
          ent_q[i].rdy1 <= 1'b1;
          ent_q[i].val1 <= cdb_value;
        end
        if (ent_q[i].valid && operand_wakes(ent_q[i].rdy2, ent_q[i].tag2, cdb_valid, cdb_tag)) begin
          ent_q[i].rdy2 <= 1'b1;
          ent_q[i].val2 <= cdb_value;
        end
      end
      if (issue_fire) ent_q[sel_idx].valid <= 1'b0;
      if (disp_fire) ent_q[free_idx] <= disp_ent;
    end
  end

  // Issue register: loads the selected entry unless stalled by execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid     <= 1'b0;
      iss_opsel1    <= '0;
      iss_opsel2    <= '0;
      iss_alu_func  <= '0;
      iss_rs1_value <= '0;
      iss_rs2_value <= '0;
      iss_imm       <= '0;
      iss_pc        <= '0;
      iss_dest_tag  <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (can_select) begin
      iss_valid <= sel_any;
      if (sel_any) begin
        iss_opsel1    <= ent_q[sel_idx].opsel1;
        iss_opsel2    <= ent_q[sel_idx].opsel2;
        iss_alu_func  <= ent_q[sel_idx].alu_func;
        iss_rs1_value <= ent_q[sel_idx].val1;
        iss_rs2_value <= ent_q[sel_idx].val2;
        iss_imm       <= ent_q[sel_idx].imm;
        iss_pc        <= ent_q[sel_idx].pc;
        iss_dest_tag  <= ent_q[sel_idx].dest_tag;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed vectors with literal expectations
// plus a per-cycle comparison against a slot/age-order model of the queue.
// Build with ISSUE_AGE_SELECT_EN defined to exercise oldest-ready selection.
module tb_issue_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        disp_valid, disp_ready;
  logic [1:0]  disp_opsel1, disp_opsel2;
  logic [3:0]  disp_alu_func;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_value, disp_rs2_value;
  logic [3:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_imm, disp_pc;
  logic [3:0]  disp_dest_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        iss_ready, iss_valid;
  logic [1:0]  iss_opsel1, iss_opsel2;
  logic [3:0]  iss_alu_func;
  logic [31:0] iss_rs1_value, iss_rs2_value, iss_imm, iss_pc;
  logic [3:0]  iss_dest_tag;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  issue_queue #(.WORD(32), .ADDR_LEN(32), .DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opsel1(disp_opsel1), .disp_opsel2(disp_opsel2), .disp_alu_func(disp_alu_func),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_dest_tag(disp_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_ready(iss_ready), .iss_valid(iss_valid),
    .iss_opsel1(iss_opsel1), .iss_opsel2(iss_opsel2), .iss_alu_func(iss_alu_func),
    .iss_rs1_value(iss_rs1_value), .iss_rs2_value(iss_rs2_value),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_dest_tag(iss_dest_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: slots plus dispatch sequence numbers ----------------
  bit          m_v [DEPTH];
  bit          m_r1 [DEPTH], m_r2 [DEPTH];
  logic [31:0] m_val1 [DEPTH], m_val2 [DEPTH], m_imm [DEPTH], m_pc [DEPTH];
  logic [3:0]  m_t1 [DEPTH], m_t2 [DEPTH], m_fn [DEPTH], m_dt [DEPTH];
  logic [1:0]  m_os1 [DEPTH], m_os2 [DEPTH];
  int          m_seq [DEPTH];
  int          seq_ctr = 0;
  bit          mi_valid = 1'b0;
  logic [31:0] mi_v1 = '0, mi_v2 = '0, mi_imm = '0, mi_pc = '0;
  logic [3:0]  mi_fn = '0, mi_dt = '0;
  logic [1:0]  mi_os1 = '0, mi_os2 = '0;
  int          pick, fidx;

  initial for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;

  always @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      mi_valid = 1'b0;
      if (reset) begin
        mi_v1 = '0; mi_v2 = '0; mi_imm = '0; mi_pc = '0;
        mi_fn = '0; mi_dt = '0; mi_os1 = '0; mi_os2 = '0;
      end
    end else begin
      fidx = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_v[i] && fidx < 0) fidx = i;
      if (!mi_valid || iss_ready) begin
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
          if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef ISSUE_AGE_SELECT_EN
            if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
            if (pick < 0) pick = i;
`endif
          end
        end
        mi_valid = (pick >= 0);
        if (pick >= 0) begin
          mi_v1 = m_val1[pick]; mi_v2 = m_val2[pick]; mi_imm = m_imm[pick];
          mi_pc = m_pc[pick]; mi_fn = m_fn[pick]; mi_dt = m_dt[pick];
          mi_os1 = m_os1[pick]; mi_os2 = m_os2[pick];
          m_v[pick] = 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && cdb_valid && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_val1[i] = cdb_value; end
        if (m_v[i] && cdb_valid && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_val2[i] = cdb_value; end
      end
      if (disp_valid && fidx >= 0) begin
        m_v[fidx]   = 1'b1;
        m_seq[fidx] = seq_ctr++;
        m_os1[fidx] = disp_opsel1; m_os2[fidx] = disp_opsel2; m_fn[fidx] = disp_alu_func;
        m_imm[fidx] = disp_imm; m_pc[fidx] = disp_pc; m_dt[fidx] = disp_dest_tag;
        m_t1[fidx] = disp_rs1_tag; m_t2[fidx] = disp_rs2_tag;
        m_r1[fidx] = disp_rs1_rdy || (cdb_valid && cdb_tag == disp_rs1_tag);
        m_val1[fidx] = disp_rs1_rdy ? disp_rs1_value : cdb_value;
        m_r2[fidx] = disp_rs2_rdy || (cdb_valid && cdb_tag == disp_rs2_tag);
        m_val2[fidx] = disp_rs2_rdy ? disp_rs2_value : cdb_value;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit any_free;
      any_free = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (!m_v[i]) any_free = 1'b1;
      chk("m_disp_ready", 64'(disp_ready), 64'(any_free));
      chk("m_iss_valid", 64'(iss_valid), 64'(mi_valid));
      if (mi_valid) begin
        chk("m_iss_rs1", 64'(iss_rs1_value), 64'(mi_v1));
        chk("m_iss_rs2", 64'(iss_rs2_value), 64'(mi_v2));
        chk("m_iss_imm", 64'(iss_imm), 64'(mi_imm));
        chk("m_iss_pc", 64'(iss_pc), 64'(mi_pc));
        chk("m_iss_func", 64'(iss_alu_func), 64'(mi_fn));
        chk("m_iss_dest", 64'(iss_dest_tag), 64'(mi_dt));
        chk("m_iss_opsel", 64'({iss_opsel1, iss_opsel2}), 64'({mi_os1, mi_os2}));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic disp(input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                      input logic [3:0] dt);
    disp_valid = 1'b1;
    disp_rs1_rdy = r1; disp_rs1_value = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_value = v2; disp_rs2_tag = t2;
    disp_dest_tag = dt; disp_alu_func = dt;
    disp_opsel1 = v1[1:0]; disp_opsel2 = v2[1:0];
    disp_imm = {v1[15:0], v2[15:0]};
    disp_pc = 32'h1000 + {26'd0, dt, 2'b00};
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; iss_ready = 1'b1;
    disp_valid = 1'b0; disp_opsel1 = '0; disp_opsel2 = '0; disp_alu_func = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_value = '0; disp_rs2_value = '0;
    disp_rs1_tag = '0; disp_rs2_tag = '0; disp_imm = '0; disp_pc = '0; disp_dest_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    cyc; cyc;
    chk_en = 1'b1;
    reset = 1'b0;
    cyc;
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_iss_data", 64'(iss_rs1_value | iss_rs2_value | iss_pc), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);

    // Ready op: visible two cycles after dispatch.
    disp(1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3); cyc;
    idle; cyc;
    chk("t1_valid", 64'(iss_valid), 64'd1);
    chk("t1_rs1", 64'(iss_rs1_value), 64'd5);
    chk("t1_rs2", 64'(iss_rs2_value), 64'd7);
    chk("t1_dest", 64'(iss_dest_tag), 64'd3);
    cyc;

    // Wakeup via CDB in cycle 3, issue visible in cycle 5.
    disp(0, 32'd0, 4'd9, 1, 32'h22, 4'd0, 4'd4); cyc;
    idle; cyc; cyc;
    bcast(4'd9, 32'h100); cyc;
    idle;
    chk("t2_not_yet", 64'(iss_valid), 64'd0);
    cyc;
    chk("t2_valid", 64'(iss_valid), 64'd1);
    chk("t2_rs1", 64'(iss_rs1_value), 64'h100);
    chk("t2_rs2", 64'(iss_rs2_value), 64'h22);
    cyc;

    // Dispatch bypass of a same-cycle broadcast.
    disp(1, 32'd1, 4'd0, 0, 32'd0, 4'd2, 4'd5);
    bcast(4'd2, 32'h55); cyc;
    idle; cyc;
    chk("t3_valid", 64'(iss_valid), 64'd1);
    chk("t3_rs2", 64'(iss_rs2_value), 64'h55);
    cyc;

    // Fill all four entries waiting on tag 1; a fifth op is held while full.
    for (int i = 0; i < 4; i++) begin
      disp(0, 32'd0, 4'd1, 1, 32'h30 + 32'(i), 4'd0, 4'(8 + i)); cyc;
    end
    disp(1, 32'hEE, 4'd0, 1, 32'hEE, 4'd0, 4'd15);
    chk("t4_full", 64'(disp_ready), 64'd0);
    cyc;
    chk("t4_full_held", 64'(disp_ready), 64'd0);
    idle; bcast(4'd1, 32'h10); cyc;
    idle;
    chk("t4_wake_edge", 64'(iss_valid), 64'd0);
    cyc;
    chk("t4_first_valid", 64'(iss_valid), 64'd1);
    chk("t4_first_rs1", 64'(iss_rs1_value), 64'h10);
    chk("t4_first_rs2", 64'(iss_rs2_value), 64'h30);
    chk("t4_ready_again", 64'(disp_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      cyc;
      chk("t4_seq_rs2", 64'(iss_rs2_value), 64'h30 + 64'(i));
    end
    cyc;
    chk("t4_drained", 64'(iss_valid), 64'd0);

    // Stall: iss_ready low for three cycles holds the issue register.
    disp(1, 32'hA1, 4'd0, 1, 32'd0, 4'd0, 4'd6); cyc;
    disp(1, 32'hB1, 4'd0, 1, 32'd0, 4'd0, 4'd7); cyc;
    idle; iss_ready = 1'b0;
    chk("t5_a", 64'(iss_rs1_value), 64'hA1);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t5_hold_valid", 64'(iss_valid), 64'd1);
      chk("t5_hold_rs1", 64'(iss_rs1_value), 64'hA1);
    end
    iss_ready = 1'b1; cyc;
    chk("t5_b", 64'(iss_rs1_value), 64'hB1);
    cyc;
    chk("t5_empty", 64'(iss_valid), 64'd0);

    // Age order: A lands in entry 2, B later in entry 0, both wake together.
    disp(0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 4'd1); cyc;
    disp(0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 4'd2); cyc;
    disp(0, 32'd0, 4'd6, 1, 32'hAA, 4'd0, 4'd12); cyc;
    idle; bcast(4'd5, 32'h5); cyc;
    idle; cyc; cyc;
    disp(0, 32'd0, 4'd6, 1, 32'hBB, 4'd0, 4'd13); cyc;
    idle; bcast(4'd6, 32'h66); cyc;
    idle; cyc;
`ifdef ISSUE_AGE_SELECT_EN
    chk("t6_first_is_A", 64'(iss_rs2_value), 64'hAA);
    cyc;
    chk("t6_second_is_B", 64'(iss_rs2_value), 64'hBB);
`else
    chk("t6_first_is_B", 64'(iss_rs2_value), 64'hBB);
    cyc;
    chk("t6_second_is_A", 64'(iss_rs2_value), 64'hAA);
`endif
    cyc;

    // Flush with three waiting entries; same-cycle dispatch and CDB are dropped.
    for (int i = 0; i < 3; i++) begin
      disp(0, 32'd0, 4'd7, 1, 32'd9, 4'd0, 4'(i)); cyc;
    end
    disp(1, 32'h99, 4'd0, 1, 32'h99, 4'd0, 4'd14);
    bcast(4'd7, 32'h77); flush = 1'b1; cyc;
    flush = 1'b0; idle;
    chk("t7_flush_valid", 64'(iss_valid), 64'd0);
    chk("t7_flush_ready", 64'(disp_ready), 64'd1);
    bcast(4'd7, 32'h78); cyc;
    idle; cyc;
    chk("t7_nothing_left", 64'(iss_valid), 64'd0);

    // Reset mid-operation discards a pending op and zeroes the issue outputs.
    disp(1, 32'h77, 4'd0, 1, 32'h1, 4'd0, 4'd9); cyc;
    idle; reset = 1'b1; cyc;
    reset = 1'b0;
    chk("t8_reset_valid", 64'(iss_valid), 64'd0);
    chk("t8_reset_rs1", 64'(iss_rs1_value), 64'd0);
    cyc;
    chk("t8_still_empty", 64'(iss_valid), 64'd0);
    chk("t8_ready", 64'(disp_ready), 64'd1);
    cyc;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
